// File: rtl/cpu_controller.sv
// Instruction register, field decode and Moore control FSM ahead of the datapath.
// Build option: CPU_ILLEGAL_TRAP_EN sends illegal opcodes to a sticky TRAP state.
module cpu_controller #(
    parameter int unsigned STATUS_ON_MOV = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WIMM, S_GETA,
        S_GETB, S_ALU, S_WREG, S_TRAP
    } state_t;

`ifdef CPU_ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = S_TRAP;
`else
    localparam state_t ILL_NEXT = S_WAIT;
`endif

    state_t      state, next;
    logic [15:0] ir;
    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, sh;
    logic        is_movi, is_movr, is_alu, is_cmp, needs_a;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    // MVN and MOV-reg are single-operand and skip the A fetch
    assign needs_a = is_alu && (op != 2'b11);

    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= '0;
        end else if (state == S_WAIT && load) begin
            ir <= in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next     = state;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 4'b0000;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        unique case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) next = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_movi: next = S_WIMM;
                    is_movr: next = S_GETB;
                    is_alu:  next = needs_a ? S_GETA : S_GETB;
                    default: next = ILL_NEXT;
                endcase
            end
            S_WIMM: begin
                writenum = rn;
                vsel     = 4'b0100;
                write    = 1'b1;
                next     = S_WAIT;
            end
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
                next    = S_GETB;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
                next    = S_ALU;
            end
            S_ALU: begin
                shift = sh;
                loadc = 1'b1;
                asel  = ~needs_a;
                ALUop = is_alu ? op : 2'b00;
                loads = is_alu ? 1'b1 : (STATUS_ON_MOV != 0);
                next  = is_cmp ? S_WAIT : S_WREG;
            end
            S_WREG: begin
                writenum = rd;
                vsel     = 4'b0001;
                write    = 1'b1;
                next     = S_WAIT;
            end
            S_TRAP: begin
                next = S_TRAP;
            end
            default: begin
                next = S_WAIT;
            end
        endcase
    end

`ifdef CPU_ILLEGAL_TRAP_EN
    assign illegal = (state == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule
